// File: rtl/addsub_multicycle_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the multi-cycle adder/subtractor.
//   state_t       : controller states (IDLE, RUN, DONE)
//   calcNChunk    : number of CHUNK-bit slices in a WIDTH-bit operand
//   calcIdxWidth  : width of the slice index register, never below 1 bit
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices the operand is broken into.
    function automatic int calcNChunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice build still needs a 1-bit index so the register exists.
    function automatic int calcIdxWidth(input int nChunk);
        return (nChunk <= 1) ? 1 : $clog2(nChunk);
    endfunction

endpackage

// File: rtl/addsub_multicycle_if.sv
// ---------------------------------------------------------------------------
// addsub_multicycle_if
// Operand/result handshake bundle for addsub_multicycle.
//   in_valid/in_ready   : operand handshake (input1, input2, S, I)
//   out_valid/out_ready : result handshake (sum, outc, borrow, overflow)
// master = producer of operands / consumer of results, slave = the block.
// ---------------------------------------------------------------------------
interface addsub_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             S;
    logic             I;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             outc;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, input1, input2, S, I, out_ready,
        input  in_ready, out_valid, sum, outc, borrow, overflow
    );

    modport slave (
        input  in_valid, input1, input2, S, I, out_ready,
        output in_ready, out_valid, sum, outc, borrow, overflow
    );
endinterface

// File: rtl/addsub_multicycle_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit ripple-carry adder used for one slice per cycle.
//   a, b     : slice operands
//   cin      : carry into bit 0
//   s        : slice sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (for signed overflow detection)
// ---------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    // Plain ripple chain: each bit's carry feeds the next bit up.
    for (genvar g = 0; g < CHUNK; g++) begin : gBit
        assign s[g]         = a[g] ^ b[g] ^ w_carry[g];
        assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
    end

    assign cout     = w_carry[CHUNK];
    assign c_msb_in = w_carry[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// ---------------------------------------------------------------------------
// addsub_multicycle
// Multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per cycle,
// least-significant slice first.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : addsub_multicycle_if.slave (operand and result handshakes)
// Subtraction is done as A + ~B + 1, so the carry register starts at S.
// ---------------------------------------------------------------------------
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_multicycle_if.slave   bus
);

    localparam int NCHUNK = calcNChunk(WIDTH, CHUNK);
    localparam int IDXW   = calcIdxWidth(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic             w_accept;
    logic             w_lastChunk;

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_sub;
    logic             r_signed;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_partial;

    logic [WIDTH-1:0] r_sum;
    logic             r_outc;
    logic             r_borrow;
    logic             r_overflow;

    logic [CHUNK-1:0] w_sliceA;
    logic [CHUNK-1:0] w_sliceB;
    logic [CHUNK-1:0] w_sliceS;
    logic             w_cout;
    logic             w_cMsbIn;
    logic [WIDTH-1:0] w_fullSum;

    // Slice currently being processed, selected by the chunk index.
    assign w_sliceA = r_opA[int'(r_idx) * CHUNK +: CHUNK];
    assign w_sliceB = r_opB[int'(r_idx) * CHUNK +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) uChunk (
        .a        (w_sliceA),
        .b        (w_sliceB),
        .cin      (r_carry),
        .s        (w_sliceS),
        .cout     (w_cout),
        .c_msb_in (w_cMsbIn)
    );

    // Partial sum with this cycle's slice merged in; on the last slice this
    // is the complete result, which avoids a separate slice-concatenation
    // path that would break when NCHUNK is 1.
    always_comb begin
        w_fullSum = r_partial;
        w_fullSum[int'(r_idx) * CHUNK +: CHUNK] = w_sliceS;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the accept and last-slice strobes that the
    // datapath keys off.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_lastChunk = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.in_valid;
                if (bus.in_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_lastChunk = (r_idx == LAST_IDX);
                if (r_idx == LAST_IDX) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, walk slices in RUN, and load the
    // result registers only when the last slice completes so the outputs
    // keep the previous result throughout IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_sub      <= 1'b0;
            r_signed   <= 1'b0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_partial  <= '0;
            r_sum      <= '0;
            r_outc     <= 1'b0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opA    <= bus.input1;
                r_opB    <= bus.S ? ~bus.input2 : bus.input2;
                r_sub    <= bus.S;
                r_signed <= bus.I;
                r_carry  <= bus.S;
                r_idx    <= '0;
            end
            if (r_state == RUN) begin
                r_partial <= w_fullSum;
                r_carry   <= w_cout;
                r_idx     <= r_idx + 1'b1;
            end
            if (w_lastChunk) begin
                r_sum      <= w_fullSum;
                r_outc     <= w_cout;
                r_borrow   <= r_sub & ~w_cout;
                r_overflow <= r_signed ? (w_cMsbIn ^ w_cout)
                                       : (r_sub ? ~w_cout : w_cout);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.outc      = r_outc;
    assign bus.borrow    = r_borrow;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_addsub_multicycle.sv
// ---------------------------------------------------------------------------
// tb_addsub_multicycle
// Directed bench for addsub_multicycle at WIDTH=16, CHUNK=4 with
// hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_addsub_multicycle;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   latency;
    int   seenValid;

    addsub_multicycle_if #(.WIDTH(WIDTH)) bus ();

    addsub_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present operands at a falling edge and hold them until the block
    // accepts them on a rising edge; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic i);
        logic wasReady;
        bit   accepted;
        accepted = 0;
        @(negedge clk);
        bus.input1   = a;
        bus.input2   = b;
        bus.S        = s;
        bus.I        = i;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wasReady = bus.in_ready;
            @(posedge clk);
            #1;
            if (wasReady) begin
                accepted = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("accept", 32'(accepted), 32'd1);
    endtask

    // Count rising edges until out_valid, bounded so a stuck block cannot
    // hang the run.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] expSum,
                               input logic expC, input logic expB,
                               input logic expV);
        checkOutput({tag, "_valid"},    32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_sum"},      32'(bus.sum),       32'(expSum));
        checkOutput({tag, "_outc"},     32'(bus.outc),      32'(expC));
        checkOutput({tag, "_borrow"},   32'(bus.borrow),    32'(expB));
        checkOutput({tag, "_overflow"}, 32'(bus.overflow),  32'(expV));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.input1    = '0;
        bus.input2    = '0;
        bus.S         = 1'b0;
        bus.I         = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #1;
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum",       32'(bus.sum),       32'd0);
        checkOutput("rst_flags",     32'({bus.outc, bus.borrow, bus.overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned add 29 + 3.
        applyStimulus(16'd29, 16'd3, 1'b0, 1'b0);
        waitResult(latency);
        checkOutput("add_latency", 32'(latency), 32'd4);
        checkResult("add", 16'd32, 1'b0, 1'b0, 1'b0);

        // Unsigned carry out; sum must hold the old value while running.
        applyStimulus(16'd65534, 16'd65100, 1'b0, 1'b0);
        checkOutput("hold_in_run", 32'(bus.sum), 32'd32);
        waitResult(latency);
        checkOutput("carry_latency", 32'(latency), 32'd4);
        checkResult("carryU", 16'hFE4A, 1'b1, 1'b0, 1'b1);

        // Same operands, signed: -2 + -436 does not overflow.
        applyStimulus(16'd65534, 16'd65100, 1'b0, 1'b1);
        waitResult(latency);
        checkResult("carryS", 16'hFE4A, 1'b1, 1'b0, 1'b0);

        // Unsigned subtract with borrow: 21 - 83.
        applyStimulus(16'd21, 16'd83, 1'b1, 1'b0);
        waitResult(latency);
        checkResult("subU", 16'hFFC2, 1'b0, 1'b1, 1'b1);

        // Signed add overflow: 32400 + 32200.
        applyStimulus(16'd32400, 16'd32200, 1'b0, 1'b1);
        waitResult(latency);
        checkResult("addSovf", 16'hFC58, 1'b0, 1'b0, 1'b1);

        // Signed subtract without overflow: 16800 - 16900 = -100.
        applyStimulus(16'd16800, 16'd16900, 1'b1, 1'b1);
        waitResult(latency);
        checkResult("subS", 16'hFF9C, 1'b0, 1'b1, 1'b0);

        // Backpressure: hold DONE three cycles while new operands are offered.
        applyStimulus(16'd100, 16'd50, 1'b0, 1'b0);
        waitResult(latency);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.input1    = 16'd7;
        bus.input2    = 16'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid",    32'(bus.out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(bus.in_ready),  32'd0);
            checkOutput("bp_sum",      32'(bus.sum),       32'd150);
            checkOutput("bp_flags",    32'({bus.outc, bus.borrow, bus.overflow}), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_release_ready", 32'(bus.in_ready),  32'd1);
        checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_no_capture", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_sum_kept",   32'(bus.sum),      32'd150);

        // Reset after two RUN cycles.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        checkOutput("mid_rst_sum",   32'(bus.sum),       32'd0);
        checkOutput("mid_rst_flags", 32'({bus.outc, bus.borrow, bus.overflow}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_no_handshake", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        seenValid    = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seenValid++;
        end
        checkOutput("no_stale_result", 32'(seenValid), 32'd0);
        checkOutput("post_rst_sum",    32'(bus.sum),   32'd0);

        applyStimulus(16'd1000, 16'd234, 1'b0, 1'b0);
        waitResult(latency);
        checkOutput("post_rst_latency", 32'(latency), 32'd4);
        checkResult("post_rst", 16'd1234, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
